// File: rtl/cpu_sequencer_if.sv
// Bus between the instruction-cycle sequencer and the CPU datapath.
//   opcode  : current IR opcode (HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7)
//   zero    : ALU zero flag (accumulator == 0)
//   mem_rd  : memory read strobe
//   mem_wr  : memory write strobe
//   load_ir : load instruction register
//   load_ac : load accumulator from ALU out
//   inc_pc  : increment program counter
//   load_pc : load PC from IR address field
//   halt    : CPU halted (sticky until reset)
//   phase   : current phase 0..7, for debug
// The master modport belongs to the sequencer, the slave modport to the datapath.
interface cpu_sequencer_if;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd;
  logic       mem_wr;
  logic       load_ir;
  logic       load_ac;
  logic       inc_pc;
  logic       load_pc;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode,
    input  zero,
    output mem_rd,
    output mem_wr,
    output load_ir,
    output load_ac,
    output inc_pc,
    output load_pc,
    output halt,
    output phase
  );

  modport slave (
    output opcode,
    output zero,
    input  mem_rd,
    input  mem_wr,
    input  load_ir,
    input  load_ac,
    input  inc_pc,
    input  load_pc,
    input  halt,
    input  phase
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller for the 8-bit RISC CPU.
// Steps a fixed 8-phase cycle per instruction and decodes the registered phase, the opcode,
// the ALU zero flag and the halted latch into datapath strobes. State changes on posedge so
// the strobes are settled when the ALU evaluates on negedge.
// Ports:
//   clk  : system clock
//   rst_ : synchronous active-low reset (clears phase and the halted latch)
//   bus  : cpu_sequencer_if.master -- opcode/zero in; strobes, halt and phase out
module cpu_sequencer #(
  parameter int unsigned NPHASE = 8
) (
  input logic             clk,
  input logic             rst_,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  localparam logic [2:0] LastPhase = 3'(NPHASE - 1);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;

  logic mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc;
  logic alu_op;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_) begin
      phase_q  <= StInstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: phase freezes once halted; HLT is committed during OP_ADDR, so the
  // frozen phase is OP_FETCH.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == LastPhase) begin
        phase_d = StInstAddr;
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
      if (phase_q == StOpAddr && bus.opcode == OpHlt) begin
        halted_d = 1'b1;
      end
    end
  end

  // Instructions that read an operand and write the accumulator
  always_comb begin
    alu_op = 1'b0;
    if (bus.opcode == OpAdd || bus.opcode == OpAnd || bus.opcode == OpXor ||
        bus.opcode == OpLda) begin
      alu_op = 1'b1;
    end
  end

  // Strobe decode
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    unique case (phase_q)
      StInstAddr: begin
      end
      StInstFetch: begin
        mem_rd = 1'b1;
      end
      StInstLoad, StIdle: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      StOpAddr: begin
        inc_pc = 1'b1;
      end
      StOpFetch: begin
        mem_rd = alu_op;
      end
      StAluOp: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        // Second increment skips the next word when SKZ sees a zero accumulator
        inc_pc  = (bus.opcode == OpSkz) && bus.zero;
        load_pc = (bus.opcode == OpJmp);
      end
      StStore: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        load_pc = (bus.opcode == OpJmp);
        mem_wr  = (bus.opcode == OpSto);
      end
    endcase
    if (halted_q) begin
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      load_ir = 1'b0;
      load_ac = 1'b0;
      inc_pc  = 1'b0;
      load_pc = 1'b0;
    end
  end

  assign bus.mem_rd  = mem_rd;
  assign bus.mem_wr  = mem_wr;
  assign bus.load_ir = load_ir;
  assign bus.load_ac = load_ac;
  assign bus.inc_pc  = inc_pc;
  assign bus.load_pc = load_pc;
  assign bus.halt    = halted_q;
  assign bus.phase   = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: the stimulus process pushes one hand-computed expected
// output vector per clock; the monitor pops and compares on every negedge.
// Strobe vectors are {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc}.
module tb_cpu_sequencer;

  logic clk;
  logic rst_;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.NPHASE(8)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [5:0] st;
    logic       hlt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  // Per-instruction expected strobes, phase 7 first, phase 0 last
  logic [47:0] t_add   = {6'b100100, 6'b100100, 6'b100000, 6'b000010,
                          6'b101000, 6'b101000, 6'b100000, 6'b000000};
  logic [47:0] t_sto   = {6'b010000, 6'b000000, 6'b000000, 6'b000010,
                          6'b101000, 6'b101000, 6'b100000, 6'b000000};
  logic [47:0] t_skz_1 = {6'b000000, 6'b000010, 6'b000000, 6'b000010,
                          6'b101000, 6'b101000, 6'b100000, 6'b000000};
  logic [47:0] t_skz_0 = {6'b000000, 6'b000000, 6'b000000, 6'b000010,
                          6'b101000, 6'b101000, 6'b100000, 6'b000000};
  logic [47:0] t_jmp   = {6'b000001, 6'b000001, 6'b000000, 6'b000010,
                          6'b101000, 6'b101000, 6'b100000, 6'b000000};
  logic [47:0] t_hlt   = {6'b000000, 6'b000000, 6'b000000, 6'b000010,
                          6'b101000, 6'b101000, 6'b100000, 6'b000000};

  // Monitor
  always @(negedge clk) begin
    logic [5:0] act;
    exp_t       e;
    n_cyc++;
    act = {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac, bus.inc_pc, bus.load_pc};
    if (rst_ && bus.phase >= 3'd3) begin
      assert (!$isunknown(bus.opcode)) else $error("opcode unknown in phase %0d", bus.phase);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.phase !== e.ph || act !== e.st || bus.halt !== e.hlt) begin
        n_fail++;
        $display("FAIL cycle%0d: got phase=%0d strobes=%b halt=%b, want phase=%0d strobes=%b halt=%b",
                 n_cyc, bus.phase, act, bus.halt, e.ph, e.st, e.hlt);
      end
      n_tests++;
      if ((bus.mem_rd && bus.mem_wr) || (bus.load_ac && bus.mem_wr)) begin
        n_fail++;
        $display("FAIL invariant cycle%0d: got strobes=%b, want no rd+wr or ac+wr", n_cyc, act);
      end
    end
  end

  task automatic push(input logic [2:0] ph, input logic [5:0] st, input logic hlt);
    exp_t e;
    e.ph  = ph;
    e.st  = st;
    e.hlt = hlt;
    sb.push_back(e);
  endtask

  // Drive one instruction for phases first..last, pushing the table entry for each cycle
  task automatic run_phases(input logic [2:0] op, input logic z, input logic [47:0] tbl,
                            input int first, input int last);
    for (int p = first; p <= last; p++) begin
      bus.opcode = op;
      bus.zero   = z;
      push(3'(p), tbl[p*6 +: 6], 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.opcode = 3'd2;
    bus.zero   = 1'b0;
    rst_       = 1'b0;
    @(posedge clk);
    #1;
    // Reset held: phase 0, everything low
    push(3'd0, 6'b000000, 1'b0);
    @(posedge clk);
    #1;
    rst_ = 1'b1;

    run_phases(3'd2, 1'b0, t_add, 0, 7);   // ADD
    run_phases(3'd6, 1'b0, t_sto, 0, 7);   // STO, also shows wrap to phase 0
    run_phases(3'd1, 1'b1, t_skz_1, 0, 7); // SKZ taken
    run_phases(3'd1, 1'b0, t_skz_0, 0, 7); // SKZ not taken
    run_phases(3'd7, 1'b0, t_jmp, 0, 7);   // JMP
    run_phases(3'd3, 1'b1, t_add, 0, 7);   // AND, zero ignored

    // HLT: normal through OP_ADDR, then frozen at phase 5
    run_phases(3'd0, 1'b0, t_hlt, 0, 4);
    for (int i = 0; i < 21; i++) begin
      bus.opcode = (i % 2 == 0) ? 3'd2 : 3'd6;
      bus.zero   = 1'(i % 3 == 0);
      push(3'd5, 6'b000000, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.opcode = 3'd2;
    bus.zero   = 1'b0;
    rst_       = 1'b0;
    push(3'd5, 6'b000000, 1'b1);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    run_phases(3'd2, 1'b0, t_add, 0, 7);   // stepping resumes after reset

    // Reset mid-instruction at phase 6 of LDA
    run_phases(3'd5, 1'b0, t_add, 0, 5);
    rst_ = 1'b0;
    push(3'd6, 6'b100100, 1'b0);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    run_phases(3'd5, 1'b0, t_add, 0, 7);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
